// File: rtl/lockstep_compare.sv
// lockstep_compare
//   Walks every 4-state stimulus vector (4^NIN of them). Each vector is held
//   SETTLE cycles and then compared for one cycle, so a vector lasts SETTLE+1
//   cycles. In the compare cycle, the reference bus and the implementation
//   bus are checked channel by channel. The block records the mismatch count,
//   sticky per-channel flags, and the first failing vector with its channel
//   mask.
//
//   Optional feature: define LOCKSTEP_STOP_ON_FAIL_EN to end the run at the
//   first mismatching vector.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle run request (ignored while busy)
//   spec_bus    in   reference outputs, {unk,val} per bit, 2*WIDTH per channel
//   impl_bus    in   implementation outputs, same encoding
//   stim_code   out  current vector, one 2-bit digit per stimulus bit
//   busy        out  run in progress
//   done        out  run complete, held until next start or rst
//   pass        out  done with zero failures
//   fail_cnt    out  mismatching vectors, saturating
//   chan_fail   out  sticky per-channel mismatch flags
//   first_vec   out  stim_code of first failing vector
//   first_mask  out  channels failing on that vector
module lockstep_compare #(
   parameter int WIDTH  = 4,
   parameter int NCHAN  = 9,
   parameter int NIN    = 8,
   parameter int SETTLE = 2,
   parameter int CNTW   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2*WIDTH*NCHAN-1:0] spec_bus,
   input  logic [2*WIDTH*NCHAN-1:0] impl_bus,
   output logic [2*NIN-1:0]         stim_code,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [CNTW-1:0]          fail_cnt,
   output logic [NCHAN-1:0]         chan_fail,
   output logic [2*NIN-1:0]         first_vec,
   output logic [NCHAN-1:0]         first_mask
);

   localparam int SW = 2*WIDTH;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE-1);

   typedef enum logic [1:0] {IDLE, SETTLE_ST, CHECK, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [NCHAN-1:0] mismatch;
   logic            any_mis;
   logic [CNTW-1:0] fail_next;
   logic            stop_now;
   logic            last_vec;

   always_comb begin
      mismatch = '0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
         mismatch[k] = (spec_bus[k*SW +: SW] !== impl_bus[k*SW +: SW]);
      end
   end

   assign any_mis   = |mismatch;
   assign fail_next = (any_mis && (fail_cnt != '1)) ? fail_cnt + 1'b1 : fail_cnt;
   assign last_vec  = (stim_code == '1);

`ifdef LOCKSTEP_STOP_ON_FAIL_EN
   assign stop_now = any_mis;
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         stim_code  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_cnt   <= '0;
         chan_fail  <= '0;
         first_vec  <= '0;
         first_mask <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= SETTLE_ST;
                  cnt        <= RELOAD;
                  stim_code  <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  fail_cnt   <= '0;
                  chan_fail  <= '0;
                  first_vec  <= '0;
                  first_mask <= '0;
               end
            end
            SETTLE_ST: begin
               if (cnt == '0) state <= CHECK;
               else           cnt   <= cnt - 1'b1;
            end
            CHECK: begin
               if (any_mis) begin
                  fail_cnt  <= fail_next;
                  chan_fail <= chan_fail | mismatch;
                  // fail_cnt saturates and never returns to zero, so zero
                  // still identifies the first failing vector of the run.
                  if (fail_cnt == '0) begin
                     first_vec  <= stim_code;
                     first_mask <= mismatch;
                  end
               end
               if (last_vec || stop_now) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_next == '0);
               end else begin
                  state     <= SETTLE_ST;
                  cnt       <= RELOAD;
                  stim_code <= stim_code + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
